mix_scheduler: RTL

- Sequences one output sample per audio slot for the audio output path.
- Waits for `audio_out_allowed` from the audio controller, then polls each enabled voice in fixed index order over a req/ack handshake.
- Accumulates the returned samples with signed saturation and drives `mix_down` / `write_audio_out` into the audio controller.
- Sits between the voice generators and the audio block; it is the only writer of the DAC FIFO.

---
 rtl/mix_sched_pkg.sv | 39 +++
 rtl/mix_saturate.sv | 17 +
 rtl/mix_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mix_sched_pkg.sv
// Shared definitions for the audio mix scheduler.
//   state_t      : scheduler FSM states
//   SAMPLE_W_DEF : default signed sample width (matches the audio controller)
//   acc_width()  : accumulator width for a given sample width / voice count
//   saturate()   : signed clamp of a wide value into sample_w bits
package mix_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WRITE
  } state_t;

  localparam int SAMPLE_W_DEF = 32;

  // Working width of saturate(); wide enough for any accumulator we build
  // (SAMPLE_W up to 59 with 8 voices).
  localparam int SAT_W = 64;

  // Sign bit + headroom for summing num_voices full-scale samples.
  function automatic int acc_width(input int sample_w, input int num_voices);
    return sample_w + $clog2(num_voices) + 1;
  endfunction

  localparam int ACC_W_DEF = acc_width(SAMPLE_W_DEF, 4);

  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] v,
    input int                      sample_w
  );
    logic signed [SAT_W-1:0] hi, lo;
    hi = (64'sd1 <<< (sample_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/mix_saturate.sv
// Combinational signed clamp from the accumulator width down to SAMPLE_W.
//   acc : signed accumulator value (ACC_W bits)
//   sat : acc clamped to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]
module mix_saturate
  import mix_sched_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int ACC_W    = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0]    acc,
  output logic signed [SAMPLE_W-1:0] sat
);

  // Widen (sign-extending) to the package working width, clamp, narrow.
  assign sat = SAMPLE_W'(saturate(SAT_W'(acc), SAMPLE_W));

endmodule

// File: rtl/mix_scheduler.sv
// Audio mix scheduler: once the audio controller reports FIFO space, polls
// each enabled voice in index order over a req/ack handshake, sums the
// returned samples with signed saturation and writes one mixed sample.
// Sole writer of the DAC FIFO.
//   CLOCK_50          : system clock
//   resetn            : async active-low reset
//   audio_out_allowed : controller FIFO has space
//   write_audio_out   : one-cycle write strobe (combinational on allowed)
//   mix_down          : saturated mixed sample, held between writes
//   voice_enable      : per-voice mix enable, sampled as each voice is reached
//   voice_req         : registered one-hot sample request
//   voice_ack         : per-voice sample-valid
//   voice_sample      : flattened samples, voice i at [i*SAMPLE_W +: SAMPLE_W]
//   voice_timeout     : sticky per-voice no-ack flag
//   sample_count      : samples written, wraps
module mix_scheduler
  import mix_sched_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int TIMEOUT    = 255
) (
  input  logic                         CLOCK_50,
  input  logic                         resetn,
  input  logic                         audio_out_allowed,
  output logic                         write_audio_out,
  output logic [SAMPLE_W-1:0]          mix_down,
  input  logic [NUM_VOICES-1:0]        voice_enable,
  output logic [NUM_VOICES-1:0]        voice_req,
  input  logic [NUM_VOICES-1:0]        voice_ack,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
  output logic [NUM_VOICES-1:0]        voice_timeout,
  output logic [15:0]                  sample_count
);

  localparam int ACC_W = acc_width(SAMPLE_W, NUM_VOICES);
  localparam int IW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_VOICES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT);

  state_t                  state, state_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [TW-1:0]           tcnt, tcnt_nxt;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic [NUM_VOICES-1:0]   req_nxt, tout_nxt;
  logic [SAMPLE_W-1:0]     mix_nxt;
  logic [15:0]             cnt_nxt;
  logic signed [SAMPLE_W-1:0] cur_sample, mix_sat;
  logic                    adv, enter;

  assign cur_sample = voice_sample[int'(idx)*SAMPLE_W +: SAMPLE_W];

  // Clamp the value the accumulator is about to take, so the final voice's
  // contribution lands in mix_down on the same edge it is summed.
  mix_saturate #(
    .SAMPLE_W (SAMPLE_W),
    .ACC_W    (ACC_W)
  ) u_sat (
    .acc (acc_nxt),
    .sat (mix_sat)
  );

  assign write_audio_out = (state == WRITE) & audio_out_allowed;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    tcnt_nxt  = tcnt;
    acc_nxt   = acc;
    req_nxt   = voice_req;
    tout_nxt  = voice_timeout;
    mix_nxt   = mix_down;
    cnt_nxt   = sample_count;
    adv       = 1'b0;
    enter     = 1'b0;

    case (state)
      IDLE: begin
        if (audio_out_allowed) begin
          state_nxt = REQ;
          idx_nxt   = '0;
          acc_nxt   = '0;
          enter     = 1'b1;
        end
      end
      REQ: begin
        // An empty voice_req means the voice was disabled when reached.
        if (voice_req == '0) begin
          adv = 1'b1;
        end else if (voice_ack[idx]) begin
          acc_nxt = acc + {{(ACC_W-SAMPLE_W){cur_sample[SAMPLE_W-1]}}, cur_sample};
          adv     = 1'b1;
        end else if (tcnt == TO_LAST) begin
          tout_nxt[idx] = 1'b1;
          adv           = 1'b1;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
        end
        if (adv) begin
          req_nxt = '0;
          if (idx == LAST_IDX) begin
            state_nxt = WRITE;
            mix_nxt   = mix_sat;
          end else begin
            idx_nxt = idx + IW'(1);
            enter   = 1'b1;
          end
        end
      end
      WRITE: begin
        if (audio_out_allowed) begin
          state_nxt = IDLE;
          cnt_nxt   = sample_count + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Entering REQ(idx): enable is sampled here and the request is raised
    // on the same edge.
    if (enter) begin
      tcnt_nxt = '0;
      req_nxt  = voice_enable[idx_nxt] ? (NUM_VOICES'(1) << idx_nxt) : '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      idx           <= '0;
      tcnt          <= '0;
      acc           <= '0;
      voice_req     <= '0;
      voice_timeout <= '0;
      mix_down      <= '0;
      sample_count  <= '0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      tcnt          <= tcnt_nxt;
      acc           <= acc_nxt;
      voice_req     <= req_nxt;
      voice_timeout <= tout_nxt;
      mix_down      <= mix_nxt;
      sample_count  <= cnt_nxt;
    end
  end

endmodule
